keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 19 +
 rtl/priority_enc16.sv | 21 ++
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared constants, FSM state type and helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int unsigned KEY_W    = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } fsm_state_t;

    // One-hot mask with only the bit for key index idx set.
    function automatic logic [NUM_KEYS-1:0] key_bit(input logic [KEY_W-1:0] idx);
        return NUM_KEYS'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_enc16.sv
// 16-bit lowest-index priority encoder with a nonzero flag.
module priority_enc16
    import keypad_scanner_pkg::*;
(
    input  logic [NUM_KEYS-1:0] mask,
    output logic [KEY_W-1:0]    idx,
    output logic                nonzero
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx     = '0;
        nonzero = |mask;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (mask[i-1]) begin
                idx = KEY_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row ring, column sampling, whole-matrix
// debounce, new-press detection and a valid/ready event handshake.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [NUM_KEYS-1:0] key_map
);

    localparam int unsigned   DW            = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST    = DW'(DWELL_CYCLES - 1);
    localparam logic [3:0]    STABLE_TARGET = 4'(DEBOUNCE_SCANS);

    logic [NUM_COLS-1:0] col_meta;
    logic [NUM_COLS-1:0] col_sync;
    logic [NUM_ROWS-1:0] ring;
    logic [DW-1:0]       dwell_cnt;
    logic                dwell_last;
    logic                scan_done;

    logic [NUM_KEYS-1:0] snap;
    logic [NUM_KEYS-1:0] snap_full;
    logic [NUM_KEYS-1:0] prev_snap;
    logic [3:0]          stable_cnt;
    logic [3:0]          stable_next;
    logic                map_load;
    logic [NUM_KEYS-1:0] new_press;

    logic [NUM_KEYS-1:0] pend;
    logic [NUM_KEYS-1:0] pend_next;
    logic [NUM_KEYS-1:0] clear_mask;

    fsm_state_t          state;
    fsm_state_t          state_next;
    logic                take;
    logic [KEY_W-1:0]    enc_idx;
    logic                enc_nonzero;

    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign scan_done  = dwell_last & ring[NUM_ROWS-1];
    assign row_out    = ~ring;

    // Two-flop synchronizer; idles high to match the external pull-ups.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    // Dwell timer; the one-hot row ring advances on the last dwell cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dwell_cnt <= '0;
            ring      <= NUM_ROWS'(1);
        end else if (dwell_last) begin
            dwell_cnt <= '0;
            ring      <= {ring[NUM_ROWS-2:0], ring[NUM_ROWS-1]};
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    // Snapshot with the currently driven row's pressed columns merged in;
    // on the row-3 sample this is the complete scan.
    always_comb begin
        snap_full = snap;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (ring[r]) begin
                snap_full[r*NUM_COLS +: NUM_COLS] = ~col_sync;
            end
        end
    end

    // Shared stability counter and key_map load decision.
    always_comb begin
        if (snap_full != prev_snap) begin
            stable_next = 4'd1;
        end else if (stable_cnt < STABLE_TARGET) begin
            stable_next = stable_cnt + 4'd1;
        end else begin
            stable_next = stable_cnt;
        end
        map_load  = scan_done && (stable_next == STABLE_TARGET);
        new_press = snap_full & ~key_map;
    end

    // Raw snapshot, previous complete scan, stability count and key_map.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            snap       <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
            key_map    <= '0;
        end else begin
            if (dwell_last) begin
                snap <= snap_full;
            end
            if (scan_done) begin
                prev_snap  <= snap_full;
                stable_cnt <= stable_next;
            end
            if (map_load) begin
                key_map <= snap_full;
            end
        end
    end

    priority_enc16 u_enc (
        .mask    (pend),
        .idx     (enc_idx),
        .nonzero (enc_nonzero)
    );

    // Handshake next-state; clearing the taken bit and ORing in new presses
    // share one update so a press landing on the take cycle is not lost.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enc_nonzero) begin
                    take       = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (key_valid && key_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        clear_mask = take ? key_bit(enc_idx) : '0;
        pend_next  = (pend & ~clear_mask) | (map_load ? new_press : '0);
    end

    // Handshake state, registered outputs and pending mask.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
            key_code  <= '0;
            pend      <= '0;
        end else begin
            state     <= state_next;
            key_valid <= (state_next == ST_PRESENT);
            pend      <= pend_next;
            if (take) begin
                key_code <= enc_idx;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a scan-level reference model.
module tb_keypad_scanner;

    localparam int unsigned DWELL = 4;
    localparam int unsigned DEB   = 3;
    localparam int unsigned SCAN  = 4 * DWELL;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] key_map;

    logic [15:0] keys;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned edge_n;
    logic [15:0] hist[$];
    logic [15:0] m_map;
    logic [15:0] m_pend;
    int unsigned rdy_mode;
    logic        prev_valid;
    logic        prev_ready;
    logic [3:0]  prev_code;
    int unsigned n_events;
    int unsigned ev_edges[$];
    int unsigned ev_codes[$];

    keypad_scanner #(
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_map   (key_map)
    );

    always #5 clk_in = ~clk_in;

    // Physical matrix: a pressed key shorts its column to its row when driven low.
    function automatic logic [3:0] matrix_cols(input logic [3:0] rows, input logic [15:0] k);
        logic [3:0] c;
        c = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (!rows[r] && k[r*4+cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign col_in = matrix_cols(row_out, keys);

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return i;
        return 16;
    endfunction

    function automatic int unsigned q_at(input int unsigned q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 999;
    endfunction

    // Debounce rule: key_map follows a snapshot once DEB consecutive scans agree.
    task automatic model_scan_end(input logic [15:0] snapshot);
        int unsigned run;
        run = 0;
        hist.push_back(snapshot);
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == snapshot) run++;
            else break;
        end
        if (run >= DEB) begin
            m_pend = m_pend | (snapshot & ~m_map);
            m_map  = snapshot;
        end
    endtask

    task automatic step();
        int unsigned lo;
        logic [3:0]  exp_row;
        @(posedge clk_in);
        #1;
        edge_n++;
        exp_row = ~(4'b0001 << ((edge_n / DWELL) % 4));
        check_eq("row_out", row_out, exp_row);
        if (prev_valid && !prev_ready) begin
            check_eq("valid_hold", key_valid, 1);
            check_eq("code_hold", key_code, prev_code);
        end
        if (prev_valid && prev_ready)
            check_eq("valid_drop", key_valid, 0);
        if (key_valid && !prev_valid) begin
            lo = lowest(m_pend);
            check_eq("event_code", key_code, lo);
            if (lo < 16) m_pend[lo] = 1'b0;
            n_events++;
            ev_edges.push_back(edge_n);
            ev_codes.push_back(key_code);
        end
        if (edge_n % SCAN == 0)
            model_scan_end(keys);
        check_eq("key_map", key_map, m_map);
        prev_valid = key_valid;
        prev_code  = key_code;
        case (rdy_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = 1'($urandom_range(0, 1));
        endcase
        prev_ready = key_ready;
    endtask

    task automatic run_scans(input int unsigned n, input logic [15:0] pattern);
        keys = pattern;
        repeat (n * SCAN) step();
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        key_ready = 1'b0;
        keys      = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst_row", row_out, 4'b1110);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_code", key_code, 0);
        check_eq("rst_map", key_map, 0);
        @(negedge clk_in);
        rst_in     = 1'b1;
        edge_n     = 0;
        hist.delete();
        m_map      = '0;
        m_pend     = '0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_code  = '0;
        n_events   = 0;
        ev_edges.delete();
        ev_codes.delete();
    endtask

    initial begin
        logic [15:0] pattern;
        rst_in    = 1'b0;
        key_ready = 1'b0;
        keys      = '0;
        rdy_mode  = 0;

        // Idle after reset: rows rotate, nothing reported.
        do_reset();
        rdy_mode = 2;
        run_scans(5, 16'h0000);
        check_eq("idle_events", n_events, 0);

        // Single press of key 6 (row 1, col 2), held without ready.
        do_reset();
        rdy_mode = 0;
        run_scans(5, 16'h0040);
        check_eq("single_events", n_events, 1);
        check_eq("single_edge", q_at(ev_edges, 0), 49);
        check_eq("single_valid", key_valid, 1);
        check_eq("single_code", key_code, 6);
        check_eq("single_map", key_map, 16'h0040);
        rdy_mode = 1;
        run_scans(2, 16'h0040);
        run_scans(5, 16'h0000);
        check_eq("single_total", n_events, 1);
        check_eq("single_idle", key_valid, 0);

        // Bounce: key 6 toggles for 4 scans, then settles.
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 4; i++)
            run_scans(1, (i % 2 == 0) ? 16'h0040 : 16'h0000);
        check_eq("bounce_map_quiet", key_map, 0);
        run_scans(4, 16'h0040);
        check_eq("bounce_events", n_events, 1);
        check_eq("bounce_edge", q_at(ev_edges, 0), 113);

        // Simultaneous keys 0, 5, 15 with ready held high.
        do_reset();
        rdy_mode = 1;
        run_scans(4, 16'h8021);
        check_eq("simul_events", n_events, 3);
        check_eq("simul_code0", q_at(ev_codes, 0), 0);
        check_eq("simul_code1", q_at(ev_codes, 1), 5);
        check_eq("simul_code2", q_at(ev_codes, 2), 15);
        check_eq("simul_gap0", q_at(ev_edges, 1) - q_at(ev_edges, 0), 2);
        check_eq("simul_gap1", q_at(ev_edges, 2) - q_at(ev_edges, 1), 2);

        // Backpressure: key 10 held unaccepted while 3 and 9 (twice) are pressed.
        do_reset();
        rdy_mode = 0;
        run_scans(3, 16'h0400);
        run_scans(3, 16'h0408);
        run_scans(3, 16'h0608);
        run_scans(3, 16'h0408);
        run_scans(3, 16'h0608);
        check_eq("bp_valid", key_valid, 1);
        check_eq("bp_code", key_code, 10);
        check_eq("bp_events_held", n_events, 1);
        rdy_mode = 1;
        run_scans(5, 16'h0000);
        check_eq("bp_events", n_events, 3);
        check_eq("bp_code0", q_at(ev_codes, 0), 10);
        check_eq("bp_code1", q_at(ev_codes, 1), 3);
        check_eq("bp_code2", q_at(ev_codes, 2), 9);
        check_eq("bp_drained", m_pend, 0);

        // Reset while an event is presented.
        do_reset();
        rdy_mode = 0;
        run_scans(4, 16'h1000);
        check_eq("mid_valid_before", key_valid, 1);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("mid_valid", key_valid, 0);
        check_eq("mid_map", key_map, 0);
        check_eq("mid_code", key_code, 0);
        check_eq("mid_row", row_out, 4'b1110);
        do_reset();
        rdy_mode = 1;
        run_scans(2, 16'h1000);
        check_eq("mid_no_stale", n_events, 0);
        run_scans(2, 16'h1000);
        check_eq("mid_events", n_events, 1);
        check_eq("mid_code_after", q_at(ev_codes, 0), 12);
        check_eq("mid_edge", q_at(ev_edges, 0), 49);

        // Random key patterns held for random scan counts, random ready.
        do_reset();
        rdy_mode = 2;
        pattern  = '0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                pattern = 16'($urandom & $urandom & $urandom);
            run_scans(1, pattern);
        end
        rdy_mode = 1;
        run_scans(6, 16'h0000);
        check_eq("rand_drained", m_pend, 0);
        check_eq("rand_idle", key_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
